cfg_sequencer: RTL
==================

CFG_SEQUENCER -- requirements
Module: cfg_sequencer

Interface
REQ-001 SHALL have parameter N_REGS, default 8, meaning the number of 16-bit configuration registers.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 48000, meaning CLOCK cycles allowed from CFG_START to TX_END (1 ms at 48 MHz).
REQ-003 SHALL have parameter MAX_RETRY, default 2, meaning retries after a timeout before abandoning.
REQ-004 CLOCK  in  1  system clock, 48 MHz; the only clock.
REQ-005 RESET  in  1  asynchronous, active-high.
REQ-006 WR_EN / WR_ADDR / WR_DATA  in  1 / 3 / 16  host write into the shadow bank.
REQ-007 COMMIT  in  1  single-cycle pulse; requests transfer of the shadow bank to the sensor.
REQ-008 FRAME_START  in  1  single-cycle pulse, already synchronous to CLOCK.
REQ-009 RD_EN / RD_ADDR  in  1 / 3  read request from the serial configuration transmitter.
REQ-010 RD_DATA  out  16  active-bank word.
REQ-011 TX_END  in  1  single-cycle pulse; transmitter finished.
REQ-012 CFG_START  out  1  single-cycle start pulse to the transmitter.
REQ-013 BUSY, PENDING, TIMEOUT_ERR  out  1 each  status flags.
REQ-014 CFG_COUNT  out  8  number of successful transfers.

Function
REQ-015 Two banks: shadow (host-written) and active (transmitter-read), each N_REGS x 16.
REQ-016 WR_EN SHALL update the shadow bank on the next edge in any state; WR_ADDR >= N_REGS is ignored.
REQ-017 RD_DATA SHALL be registered, 1-cycle latency after RD_EN, and hold otherwise; out-of-range RD_ADDR SHALL return 16'h0000.
REQ-018 FSM states: IDLE, ARM, START, SEND.
REQ-019 IDLE: on COMMIT, copy shadow to active, set PENDING, go to ARM; retry count = 0.
REQ-020 ARM: on FRAME_START, go to START; writes and COMMIT remain accepted.
REQ-021 START: assert CFG_START for exactly one cycle, clear the timeout counter, go to SEND.
REQ-022 SEND: on TX_END, increment CFG_COUNT (wrapping 255 -> 0); if a deferred commit is held, copy shadow to active and go to ARM, otherwise clear PENDING and go to IDLE.
REQ-023 SEND: when the timeout counter reaches TIMEOUT_CYC without TX_END, set TIMEOUT_ERR; if retries < MAX_RETRY, increment retries and go to ARM, otherwise clear PENDING and go to IDLE.
REQ-024 COMMIT in ARM SHALL recopy shadow to active immediately; COMMIT in START or SEND SHALL only set the deferred-commit flag. The active bank never changes during START or SEND.
REQ-025 WR_EN and COMMIT in the same cycle: the written word SHALL be included in the copy (write-first).
REQ-026 TX_END and timeout expiry in the same cycle: TX_END wins.
REQ-027 TX_END outside SEND SHALL be ignored; FRAME_START outside ARM SHALL be ignored.
REQ-028 BUSY SHALL be 1 in START and SEND.
REQ-029 TIMEOUT_ERR SHALL be sticky, cleared only by RESET or by a COMMIT accepted in IDLE.

Reset
REQ-030 On RESET: state IDLE; both banks, RD_DATA, CFG_COUNT, retry count, and timeout counter = 0; CFG_START, BUSY, PENDING, TIMEOUT_ERR, deferred flag = 0.
REQ-031 RESET during SEND SHALL abort with no CFG_START and no CFG_COUNT increment.

Structure
REQ-032 State encoding, N_REGS, data width and the TIMEOUT_CYC default SHALL reside in the shared package cfg_pkg.
REQ-033 The register banks SHALL be one sub-module, cfg_regbank (shadow, active, copy strobe, read port); the FSM SHALL live in cfg_sequencer.

Verification
REQ-034 Write addr 2 = 16'hA5A5, COMMIT, FRAME_START -> CFG_START one cycle later; RD_EN addr 2 -> RD_DATA 16'hA5A5 next cycle; TX_END -> CFG_COUNT 1, PENDING 0.
REQ-035 COMMIT during SEND after writing addr 0 = 16'h1234 -> active addr 0 unchanged until TX_END, then 16'h1234 and a second CFG_START on the next FRAME_START.
REQ-036 No TX_END for 48000 cycles, three times -> TIMEOUT_ERR=1, CFG_START count 3, final state IDLE.
REQ-037 TX_END coincident with the timeout cycle -> CFG_COUNT increments, TIMEOUT_ERR stays 0.
REQ-038 RESET asserted mid-SEND -> all outputs 0 asynchronously; a subsequent TX_END is ignored.
REQ-039 CFG_COUNT at 255 + a successful transfer -> 0.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared definitions for the sensor configuration sequencer: sizes, defaults,
// FSM state encoding and a counter-width helper.
package cfg_pkg;

    localparam int DATA_W          = 16;
    localparam int ADDR_W          = 3;
    localparam int COUNT_W         = 8;
    localparam int N_REGS_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 48000;
    localparam int MAX_RETRY_DEF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_START = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cfg_regbank.sv
// Shadow (host-written) and active (transmitter-read) register banks with a
// whole-bank copy strobe and a registered read port on the active bank.
module cfg_regbank
    import cfg_pkg::*;
#(
    parameter int N_REGS = N_REGS_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              copy,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] shadow_reg [N_REGS];
    logic [DATA_W-1:0] active_reg [N_REGS];
    logic [N_REGS-1:0] hit;

    // Addresses at or beyond N_REGS match no entry, so such writes vanish.
    generate
        for (genvar gi = 0; gi < N_REGS; gi++) begin : g_hit
            assign hit[gi] = wr_en && (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    // A word written in the copy cycle goes straight into the active bank too.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (hit[i])
                    shadow_reg[i] <= wr_data;
                if (copy)
                    active_reg[i] <= hit[i] ? wr_data : shadow_reg[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= (int'(rd_addr) < N_REGS) ? active_reg[rd_addr] : '0;
    end

endmodule

// File: rtl/cfg_sequencer.sv
// Configuration sequencer: commits the shadow bank to the active bank and
// hands it to the serial transmitter on a frame boundary, with timeout/retry.
module cfg_sequencer
    import cfg_pkg::*;
#(
    parameter int N_REGS      = N_REGS_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               commit,
    input  logic               frame_start,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               tx_end,
    output logic               cfg_start,
    output logic               busy,
    output logic               pending,
    output logic               timeout_err,
    output logic [COUNT_W-1:0] cfg_count
);

    localparam int TW = cnt_width(TIMEOUT_CYC);
    localparam int RW = cnt_width(MAX_RETRY);

    state_t             state_reg, state_next;
    logic               pending_reg, pending_next;
    logic               terr_reg, terr_next;
    logic               deferred_reg, deferred_next;
    logic [RW-1:0]      retry_reg, retry_next;
    logic [TW-1:0]      timer_reg, timer_next;
    logic [COUNT_W-1:0] count_reg, count_next;
    logic               copy;

    cfg_regbank #(.N_REGS(N_REGS)) u_regbank (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .copy    (copy),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            pending_reg  <= 1'b0;
            terr_reg     <= 1'b0;
            deferred_reg <= 1'b0;
            retry_reg    <= '0;
            timer_reg    <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            terr_reg     <= terr_next;
            deferred_reg <= deferred_next;
            retry_reg    <= retry_next;
            timer_reg    <= timer_next;
            count_reg    <= count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pending_next  = pending_reg;
        terr_next     = terr_reg;
        deferred_next = deferred_reg;
        retry_next    = retry_reg;
        timer_next    = timer_reg;
        count_next    = count_reg;
        copy          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (commit) begin
                    copy          = 1'b1;
                    pending_next  = 1'b1;
                    terr_next     = 1'b0;
                    retry_next    = '0;
                    deferred_next = 1'b0;
                    state_next    = ST_ARM;
                end
            end
            ST_ARM: begin
                if (commit)
                    copy = 1'b1;
                if (frame_start)
                    state_next = ST_START;
            end
            ST_START: begin
                timer_next = '0;
                if (commit)
                    deferred_next = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                // The active bank is frozen here; a commit arriving now is
                // applied only when leaving SEND towards ARM.
                if (tx_end) begin
                    count_next = count_reg + 8'd1;
                    retry_next = '0;
                    if (deferred_reg || commit) begin
                        copy          = 1'b1;
                        deferred_next = 1'b0;
                        state_next    = ST_ARM;
                    end else begin
                        pending_next = 1'b0;
                        state_next   = ST_IDLE;
                    end
                end else if (timer_reg == TW'(TIMEOUT_CYC - 1)) begin
                    terr_next = 1'b1;
                    if (retry_reg < RW'(MAX_RETRY)) begin
                        retry_next = retry_reg + RW'(1);
                        state_next = ST_ARM;
                        if (deferred_reg || commit) begin
                            copy          = 1'b1;
                            deferred_next = 1'b0;
                        end
                    end else begin
                        pending_next  = 1'b0;
                        deferred_next = 1'b0;
                        state_next    = ST_IDLE;
                    end
                end else begin
                    timer_next = timer_reg + TW'(1);
                    if (commit)
                        deferred_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cfg_start   = (state_reg == ST_START);
    assign busy        = (state_reg == ST_START) || (state_reg == ST_SEND);
    assign pending     = pending_reg;
    assign timeout_err = terr_reg;
    assign cfg_count   = count_reg;

endmodule
